// File: rtl/imem_boot_loader.sv
// Byte-stream boot loader: takes a 16-bit word-count header, packs bytes little-endian into 32-bit
// instruction-memory writes, and holds the core in reset until the image is in. Optional macro: BOOT_LOADER_CHECKSUM_EN.
module imem_boot_loader #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   words_loaded,
    output logic              busy,
    output logic              cpu_run,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
`ifdef BOOT_LOADER_CHECKSUM_EN
        S_CHK,
`endif
        S_DONE,
        S_ERROR
    } state_t;

    state_t      state, state_next;
    logic [7:0]  len_lo;
    logic [15:0] word_count;
    logic [1:0]  byte_idx;
    logic [23:0] word_buf;
`ifdef BOOT_LOADER_CHECKSUM_EN
    logic [7:0]  csum;
`endif

    logic        accept;
    logic        start_ok;
    logic        last_word;
    logic [15:0] header;

    assign accept    = in_valid && in_ready;
    assign start_ok  = start && (state == S_IDLE || state == S_DONE || state == S_ERROR);
    assign header    = {in_data, len_lo};
    assign last_word = (16'(words_loaded) + 16'd1) == word_count;

`ifdef BOOT_LOADER_CHECKSUM_EN
    assign in_ready = (state == S_LEN_LO) || (state == S_LEN_HI) || (state == S_DATA) || (state == S_CHK);
`else
    assign in_ready = (state == S_LEN_LO) || (state == S_LEN_HI) || (state == S_DATA);
`endif
    assign busy    = in_ready;
    assign err     = (state == S_ERROR);
    // The final write pulse and the core release must never share a cycle.
    assign cpu_run = (state == S_DONE) && !imem_we;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    // NOTE: default assigned first so no path through the case leaves state_next unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (start) state_next = S_LEN_LO;
            S_LEN_LO: if (accept) state_next = S_LEN_HI;
            S_LEN_HI: if (accept) begin
`ifdef BOOT_LOADER_CHECKSUM_EN
                if (header == 16'd0) state_next = S_CHK;
`else
                if (header == 16'd0) state_next = S_DONE;
`endif
                else if ({16'd0, header} > 32'(DEPTH)) state_next = S_ERROR;
                else state_next = S_DATA;
            end
            S_DATA: if (accept && byte_idx == 2'd3 && last_word) begin
`ifdef BOOT_LOADER_CHECKSUM_EN
                state_next = S_CHK;
`else
                state_next = S_DONE;
`endif
            end
`ifdef BOOT_LOADER_CHECKSUM_EN
            S_CHK: if (accept) state_next = (in_data == csum) ? S_DONE : S_ERROR;
`endif
            S_DONE, S_ERROR: if (start) state_next = S_LEN_LO;
            default: state_next = S_IDLE;
        endcase
    end

    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_lo       <= '0;
            word_count   <= '0;
            byte_idx     <= '0;
            word_buf     <= '0;
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= '0;
            words_loaded <= '0;
`ifdef BOOT_LOADER_CHECKSUM_EN
            csum         <= '0;
`endif
        end else begin
            imem_we <= 1'b0;
            if (start_ok) begin
                words_loaded <= '0;
                byte_idx     <= '0;
`ifdef BOOT_LOADER_CHECKSUM_EN
                csum         <= '0;
`endif
            end
            if (accept) begin
                case (state)
                    S_LEN_LO: len_lo     <= in_data;
                    S_LEN_HI: word_count <= header;
                    S_DATA: begin
                        byte_idx <= byte_idx + 2'd1;
`ifdef BOOT_LOADER_CHECKSUM_EN
                        csum     <= csum ^ in_data;
`endif
                        if (byte_idx == 2'd3) begin
                            imem_we      <= 1'b1;
                            imem_addr    <= words_loaded[ADDR_W-1:0];
                            imem_wdata   <= {in_data, word_buf};
                            words_loaded <= words_loaded + 1'b1;
                        end else begin
                            word_buf[{byte_idx, 3'b000} +: 8] <= in_data;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: expected memory writes are queued as bytes are driven
// and checked by a monitor when imem_we pulses; status outputs are asserted at each step.
module tb_imem_boot_loader;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 256;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = 8'h00;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic [ADDR_W:0]   words_loaded;
    logic              busy;
    logic              cpu_run;
    logic              err;

    int checks = 0;
    int errors = 0;
    logic [39:0] exp_q[$];   // {addr, data}
    logic [7:0]  run_xor;

    imem_boot_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .words_loaded(words_loaded), .busy(busy), .cpu_run(cpu_run), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Write monitor: every imem_we pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && imem_we) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {24'd0, imem_addr}, 32'hFFFF_FFFF);
            end else begin
                logic [39:0] e;
                e = exp_q.pop_front();
                check("write_addr", {24'd0, imem_addr}, {24'd0, e[39:32]});
                check("write_data", imem_wdata, e[31:0]);
                check("run_during_write", {31'd0, cpu_run}, 32'd0);
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        run_xor = 8'h00;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("in_ready_timeout", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] addr, input logic [31:0] w, input bit gaps);
        for (int i = 0; i < 4; i++) begin
            logic [7:0] b;
            b = w[8*i +: 8];
            if (i == 3) exp_q.push_back({addr, w});
            send_byte(b);
            run_xor = run_xor ^ b;
            if (gaps && i != 3) @(negedge clk);
        end
    endtask

    task automatic send_checksum();
`ifdef BOOT_LOADER_CHECKSUM_EN
        send_byte(run_xor);
`endif
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_we"},    {31'd0, imem_we}, 32'd0);
        check({tag, "_addr"},  {24'd0, imem_addr}, 32'd0);
        check({tag, "_wdata"}, imem_wdata, 32'd0);
        check({tag, "_words"}, {23'd0, words_loaded}, 32'd0);
        check({tag, "_busy"},  {31'd0, busy}, 32'd0);
        check({tag, "_ready"}, {31'd0, in_ready}, 32'd0);
        check({tag, "_run"},   {31'd0, cpu_run}, 32'd0);
        check({tag, "_err"},   {31'd0, err}, 32'd0);
    endtask

    initial begin
        run_xor = 8'h00;
        #1;
        check_all_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // T1: single word
        pulse_start();
        check("t1_busy", {31'd0, busy}, 32'd1);
        send_byte(8'h01);
        send_byte(8'h00);
        send_word(8'd0, 32'h0050_0293, 1'b0);
        check("t1_we", {31'd0, imem_we}, 32'd1);
        check("t1_run_low", {31'd0, cpu_run}, 32'd0);
        check("t1_words", {23'd0, words_loaded}, 32'd1);
        send_checksum();
        @(negedge clk);
        check("t1_run", {31'd0, cpu_run}, 32'd1);
        check("t1_we_off", {31'd0, imem_we}, 32'd0);

        // T2: N=3 with in_valid toggling, plus a start while busy that must be ignored
        pulse_start();
        check("t2_run_cleared", {31'd0, cpu_run}, 32'd0);
        check("t2_words_cleared", {23'd0, words_loaded}, 32'd0);
        send_byte(8'h03);
        @(negedge clk);
        send_byte(8'h00);
        @(negedge clk);
        send_word(8'd0, 32'hDEAD_BEEF, 1'b1);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        send_word(8'd1, 32'h1234_5678, 1'b1);
        @(negedge clk);
        send_word(8'd2, 32'hA5C3_0F81, 1'b1);
        send_checksum();
        @(negedge clk);
        check("t2_words", {23'd0, words_loaded}, 32'd3);
        check("t2_ready", {31'd0, in_ready}, 32'd0);
        check("t2_run", {31'd0, cpu_run}, 32'd1);
        check("t2_all_written", exp_q.size(), 32'd0);

        // T3: N=257 exceeds DEPTH
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h01);
        check("t3_err", {31'd0, err}, 32'd1);
        check("t3_ready", {31'd0, in_ready}, 32'd0);
        repeat (3) @(negedge clk);
        check("t3_err_sticky", {31'd0, err}, 32'd1);
        check("t3_run", {31'd0, cpu_run}, 32'd0);

        // Boundary: N=256 is accepted
        pulse_start();
        check("n256_err_cleared", {31'd0, err}, 32'd0);
        send_byte(8'h00);
        send_byte(8'h01);
        check("n256_err", {31'd0, err}, 32'd0);
        check("n256_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_all_zero("n256_rst");
        @(negedge clk);
        rst_n = 1'b1;

        // T4: reset after 6 data bytes of N=2, then reload
        pulse_start();
        send_byte(8'h02);
        send_byte(8'h00);
        send_word(8'd0, 32'h0403_0201, 1'b0);
        send_byte(8'h05);
        send_byte(8'h06);
        rst_n = 1'b0;
        #1;
        check_all_zero("t4_rst");
        @(negedge clk);
        rst_n = 1'b1;
        pulse_start();
        send_byte(8'h02);
        send_byte(8'h00);
        send_word(8'd0, 32'hCAFE_F00D, 1'b0);
        send_word(8'd1, 32'h0000_0013, 1'b0);
        send_checksum();
        @(negedge clk);
        check("t4_words", {23'd0, words_loaded}, 32'd2);
        check("t4_run", {31'd0, cpu_run}, 32'd1);

        // T5: empty image
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h00);
`ifdef BOOT_LOADER_CHECKSUM_EN
        send_byte(8'h00);
`endif
        check("t5_busy", {31'd0, busy}, 32'd0);
        check("t5_run", {31'd0, cpu_run}, 32'd1);
        check("t5_words", {23'd0, words_loaded}, 32'd0);

`ifdef BOOT_LOADER_CHECKSUM_EN
        // T6: checksum good then bad
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h00);
        send_word(8'd0, 32'h0000_0013, 1'b0);
        send_byte(8'h13);
        check("t6_good_run", {31'd0, cpu_run}, 32'd1);
        check("t6_good_err", {31'd0, err}, 32'd0);
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h00);
        send_word(8'd0, 32'h0000_0013, 1'b0);
        send_byte(8'h12);
        check("t6_bad_err", {31'd0, err}, 32'd1);
        check("t6_bad_run", {31'd0, cpu_run}, 32'd0);
`endif

        repeat (2) @(negedge clk);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
